// File: rtl/matmul_stream_unit.sv
// Streaming outer-product matrix multiplier: C[M x N] = A[M x K] * B[K x N], signed.
// Define MATMUL_SAT_EN for saturating accumulation with a sticky overflow flag; default wraps.
module matmul_stream_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int M_DIM      = 3,
    parameter int K_DIM      = 3,
    parameter int N_DIM      = 3,
    parameter int CNT_WIDTH  = $clog2(K_DIM + 1)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               abort,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [M_DIM*DATA_WIDTH-1:0]        in_a_col,
    input  logic [N_DIM*DATA_WIDTH-1:0]        in_b_row,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [M_DIM*N_DIM*ACC_WIDTH-1:0]   result,
    output logic [CNT_WIDTH-1:0]               beat_cnt,
    output logic                               overflow
);

    localparam int NUM_EL = M_DIM * N_DIM;
    localparam int PROD_W = 2 * DATA_WIDTH;
`ifdef MATMUL_SAT_EN
    // One spare bit over the wider operand so the sum never wraps before clipping.
    localparam int SUM_W = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W - ACC_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W - ACC_WIDTH + 1){1'b1}}, {(ACC_WIDTH - 1){1'b0}}};
`else
    localparam int SUM_W = ACC_WIDTH;
`endif
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(K_DIM - 1);

    typedef enum logic [0:0] {StAccum, StDone} state_e;

    state_e                      r_state, w_state_next;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic [ACC_WIDTH-1:0]        r_acc      [NUM_EL];
    logic [ACC_WIDTH-1:0]        w_acc_next [NUM_EL];
    logic signed [PROD_W-1:0]    w_prod     [NUM_EL];
    logic signed [SUM_W-1:0]     w_base     [NUM_EL];
    logic signed [SUM_W-1:0]     w_sum      [NUM_EL];
    logic                        w_accept;
    logic                        w_first;
    logic                        w_last;
    logic                        w_handshake;

    assign w_accept    = in_valid && (r_state == StAccum);
    assign w_first     = (r_cnt == '0);
    assign w_last      = (r_cnt == LAST_BEAT);
    assign w_handshake = out_valid && out_ready;
    assign beat_cnt    = r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StAccum;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            StAccum: begin
                in_ready = 1'b1;
                if (w_accept && w_last) w_state_next = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = StAccum;
            end
            default: w_state_next = StAccum;
        endcase
        if (abort) w_state_next = StAccum;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (abort || w_handshake) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

`ifdef MATMUL_SAT_EN
    logic [NUM_EL-1:0] w_clip;
    logic              r_ovf;
`endif

    // Outer-product update: element (r,c) takes A[r][k] * B[k][c].
    always_comb begin
`ifdef MATMUL_SAT_EN
        w_clip = '0;
`endif
        for (int i = 0; i < NUM_EL; i++) begin
            w_prod[i] = $signed(in_a_col[(M_DIM-1-i/N_DIM)*DATA_WIDTH +: DATA_WIDTH]) *
                        $signed(in_b_row[(N_DIM-1-i%N_DIM)*DATA_WIDTH +: DATA_WIDTH]);
            w_base[i] = w_first ? '0 : SUM_W'($signed(r_acc[i]));
            w_sum[i]  = SUM_W'(w_prod[i]) + w_base[i];
`ifdef MATMUL_SAT_EN
            if (w_sum[i] > SAT_MAX) begin
                w_acc_next[i] = SAT_MAX[ACC_WIDTH-1:0];
                w_clip[i]     = 1'b1;
            end else if (w_sum[i] < SAT_MIN) begin
                w_acc_next[i] = SAT_MIN[ACC_WIDTH-1:0];
                w_clip[i]     = 1'b1;
            end else begin
                w_acc_next[i] = w_sum[i][ACC_WIDTH-1:0];
            end
`else
            w_acc_next[i] = w_sum[i];
`endif
        end
    end

    // Accumulators are never cleared by abort; the next first beat overwrites them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_EL; i++) r_acc[i] <= '0;
        end else if (w_accept && !abort) begin
            for (int i = 0; i < NUM_EL; i++) r_acc[i] <= w_acc_next[i];
        end
    end

    always_comb begin
        result = '0;
        for (int i = 0; i < NUM_EL; i++) begin
            result[(NUM_EL-1-i)*ACC_WIDTH +: ACC_WIDTH] = r_acc[i];
        end
    end

`ifdef MATMUL_SAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (abort || w_handshake) begin
            r_ovf <= 1'b0;
        end else if (w_accept && |w_clip) begin
            r_ovf <= 1'b1;
        end
    end
    assign overflow = r_ovf;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_stream_unit.sv
// Randomised scoreboard bench for matmul_stream_unit (default 3x3x3, 8-bit operands, 16-bit acc).
module tb_matmul_stream_unit;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int M  = 3;
    localparam int K  = 3;
    localparam int N  = 3;
    localparam int CW = $clog2(K + 1);
    localparam int RW = M * N * AW;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            abort = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [M*DW-1:0] in_a_col = '0;
    logic [N*DW-1:0] in_b_row = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [RW-1:0]   result;
    logic [CW-1:0]   beat_cnt;
    logic            overflow;

    matmul_stream_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a_col  (in_a_col),
        .in_b_row  (in_b_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .beat_cnt  (beat_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [RW-1:0] exp_res_q[$];
    logic          exp_ovf_q[$];
    logic [RW-1:0] exp_last;
    int            ma[M][K];
    int            mb[K][N];
    bit            rand_or = 1'b0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference: C = A*B from integer arithmetic, clipped per step only in saturating builds.
    task automatic model(output logic [RW-1:0] res, output logic ovf);
        longint acc;
        res = '0;
        ovf = 1'b0;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                acc = 0;
                for (int k = 0; k < K; k++) begin
                    acc = acc + longint'(ma[r][k]) * longint'(mb[k][c]);
`ifdef MATMUL_SAT_EN
                    if (acc > 32767) begin acc = 32767; ovf = 1'b1; end
                    if (acc < -32768) begin acc = -32768; ovf = 1'b1; end
`endif
                end
                res[(M*N-1-(r*N+c))*AW +: AW] = AW'(acc);
            end
        end
    endtask

    function automatic int rnd8();
        logic signed [DW-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = 8'sd127;
            1:       v = -8'sd128;
            default: v = DW'($urandom);
        endcase
        return int'(v);
    endfunction

    task automatic set_beat(input int k);
        for (int r = 0; r < M; r++) in_a_col[(M-1-r)*DW +: DW] = DW'(ma[r][k]);
        for (int c = 0; c < N; c++) in_b_row[(N-1-c)*DW +: DW] = DW'(mb[k][c]);
    endtask

    // Called at a negedge with inputs set; returns at the negedge after acceptance.
    task automatic wait_accept();
        in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if (in_ready) begin
                @(posedge clk);
                @(negedge clk);
                return;
            end
            @(negedge clk);
            if (rand_or) out_ready = 1'($urandom);
        end
        check("accept_timeout", 1, 0);
    endtask

    task automatic do_product(input bit gaps);
        logic [RW-1:0] res;
        logic          ovf;
        model(res, ovf);
        for (int k = 0; k < K; k++) begin
            set_beat(k);
            wait_accept();
            if (k == K - 1) begin
                exp_res_q.push_back(res);
                exp_ovf_q.push_back(ovf);
                exp_last = res;
            end
            check("beat_cnt", RW'(beat_cnt), RW'(k + 1));
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    if (rand_or) out_ready = 1'($urandom);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        rand_or   = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && exp_res_q.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", RW'(exp_res_q.size()), '0);
    endtask

    task automatic load_identity();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                ma[r][c] = (r == c) ? 1 : 0;
                mb[r][c] = r * 3 + c + 1;
            end
    endtask

    task automatic load_const(input int a, input int b);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                ma[r][c] = a;
                mb[r][c] = b;
            end
    endtask

    // Scoreboard monitor: compare every handshaken result with the oldest expectation.
    always @(negedge clk) begin
        #2;
        if (reset_n && out_valid && out_ready) begin
            if (exp_res_q.size() == 0) begin
                check("unexpected_output", RW'(1), RW'(0));
            end else begin
                check("result", result, exp_res_q.pop_front());
                check("overflow", RW'(overflow), RW'(exp_ovf_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_result", result, '0);
        check("rst_beat_cnt", RW'(beat_cnt), '0);
        check("rst_out_valid", RW'(out_valid), '0);
        check("rst_overflow", RW'(overflow), '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", RW'(in_ready), RW'(1));

        // Identity, back-to-back, consumer always ready
        out_ready = 1'b1;
        load_identity();
        do_product(1'b0);
        check("id_out_valid", RW'(out_valid), RW'(1));
        check("id_in_ready_low", RW'(in_ready), RW'(0));
        @(negedge clk);
        check("id_in_ready_back", RW'(in_ready), RW'(1));
        check("id_out_valid_fall", RW'(out_valid), RW'(0));

        // Signed operands
        load_const(-2, 3);
        do_product(1'b0);
        drain();

        // Backpressure with a beat waiting on the input
        out_ready = 1'b0;
        load_const(5, -7);
        do_product(1'b0);
        load_identity();
        set_beat(0);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_result", result, exp_last);
            check("bp_in_ready", RW'(in_ready), RW'(0));
            check("bp_beat_cnt", RW'(beat_cnt), RW'(K));
            @(negedge clk);
        end
        out_ready = 1'b1;
        do_product(1'b0);
        drain();

        // Overflow corner
        load_const(127, 127);
        do_product(1'b0);
        drain();

        // Abort on beat 2
        load_identity();
        set_beat(0);
        wait_accept();
        set_beat(1);
        abort = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_beat_cnt", RW'(beat_cnt), '0);
        check("abort_out_valid", RW'(out_valid), '0);
        do_product(1'b0);
        drain();

        // Asynchronous reset mid-product
        load_const(3, 4);
        set_beat(0);
        wait_accept();
        set_beat(1);
        wait_accept();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("arst_result", result, '0);
        check("arst_beat_cnt", RW'(beat_cnt), '0);
        check("arst_out_valid", RW'(out_valid), '0);
        check("arst_overflow", RW'(overflow), '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        load_identity();
        do_product(1'b1);
        drain();

        // Random products, random gaps and random consumer backpressure
        rand_or = 1'b1;
        for (int p = 0; p < 30; p++) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    ma[r][c] = rnd8();
                    mb[r][c] = rnd8();
                end
            do_product(1'b1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
